mod_counter: RTL

Parametrised modulo counter with programmable step, direction, limit and load, plus a run-control state machine supporting continuous and one-shot modes. Successor to the plain enable counter; used for PC-style sequencing, loop/timeout counting and multi-cycle control sequencing in the MIPS datapath. Emits a one-cycle terminal-count pulse on every wrap or clamp event.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_step.sv | 56 +++++
 rtl/mod_counter.sv | 93 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo counter block.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;

endpackage

// File: rtl/counter_step.sv
// Combinational next-value and terminal flag for one counter tick.
// MOD_COUNTER_SAT_EN selects clamping at the bounds instead of wrapping.
module counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STEP_WIDTH = 8
) (
    input  logic [WIDTH-1:0]      count_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic                  dir_i,
    input  logic [WIDTH-1:0]      limit_i,
    output logic [WIDTH-1:0]      next_o,
    output logic                  term_o
);

    // One extra bit so limit = all-ones still has a representable limit+1.
    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] lim_ext;
    logic [WIDTH:0] lim1;
    logic [WIDTH:0] sum;
    logic           up_term;
    logic           dn_term;

    // Evaluate both directions, then pick by dir.
    always_comb begin
        cnt_ext  = {1'b0, count_i};
        step_ext = (WIDTH+1)'(step_i);
        lim_ext  = {1'b0, limit_i};
        lim1     = lim_ext + (WIDTH+1)'(1);
        sum      = cnt_ext + step_ext;
        // A zero step never counts as terminal, even if limit was lowered.
        up_term  = (step_i != '0) && (sum > lim_ext);
        dn_term  = cnt_ext < step_ext;
        next_o   = count_i;
        term_o   = 1'b0;
        if (dir_i == DIR_UP) begin
            term_o = up_term;
`ifdef MOD_COUNTER_SAT_EN
            next_o = up_term ? limit_i : WIDTH'(sum);
`else
            next_o = up_term ? WIDTH'(sum - lim1) : WIDTH'(sum);
`endif
        end else begin
            term_o = dn_term;
`ifdef MOD_COUNTER_SAT_EN
            next_o = dn_term ? '0 : WIDTH'(cnt_ext - step_ext);
`else
            next_o = dn_term ? WIDTH'(cnt_ext + lim1 - step_ext)
                             : WIDTH'(cnt_ext - step_ext);
`endif
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo counter with programmable step/direction/limit, load, and a
// run-control FSM (continuous / one-shot). Optional macro
// MOD_COUNTER_SAT_EN switches wrap arithmetic to saturating arithmetic.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      init,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  en,
    input  logic                  dir,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      limit,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] step_next;
    logic             step_term;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    counter_step #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_step (
        .count_i (count_q),
        .step_i  (step),
        .dir_i   (dir),
        .limit_i (limit),
        .next_o  (step_next),
        .term_o  (step_term)
    );

    // Next state: load beats start, start beats tick; tc only from a tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = clamp(load_val, limit);
            if (state_q == DONE) state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (en) begin
                        count_d = step_next;
                        tc_d    = step_term;
                        if (step_term && mode == MODE_ONESHOT) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= clamp(init, limit);
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule
